// File: rtl/video_write_buffer_if.sv
// Bus bundle for video_write_buffer.
//   Store tap (core -> buffer): video_we, video_addr, video_data
//   VRAM write port (buffer -> VRAM): vram_valid, vram_addr, vram_data, with vram_ready returned
// The slave modport is the buffer's view. The master modport is the view of the core/VRAM side.
interface video_write_buffer_if #(
  parameter int ADDR_W = 15
);
  logic              video_we;
  logic [31:0]       video_addr;
  logic [31:0]       video_data;
  logic              vram_valid;
  logic              vram_ready;
  logic [ADDR_W-1:0] vram_addr;
  logic [31:0]       vram_data;

  modport slave (
    input  video_we, video_addr, video_data, vram_ready,
    output vram_valid, vram_addr, vram_data
  );

  modport master (
    output video_we, video_addr, video_data, vram_ready,
    input  vram_valid, vram_addr, vram_data
  );
endinterface

// File: rtl/video_write_buffer.sv
// video_write_buffer: captures single-cycle video store pulses from the core and range-checks them.
// It translates each in-range byte address to a framebuffer word index and queues {index, data}
// in a first-word-fall-through FIFO. The FIFO drains over a valid/ready VRAM write port.
// The core is never stalled. A store that cannot be queued is dropped and counted.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         store tap + VRAM write port (slave view of video_write_buffer_if)
//   clr_err     clears overflow, oor and drop_count (FIFO contents untouched)
//   level       current FIFO occupancy (0..DEPTH)
//   overflow    sticky: an in-range store was lost because the FIFO was full
//   drop_count  saturating count of lost stores (full or out of range)
//   oor         sticky: a store fell outside the framebuffer window
module video_write_buffer #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] VRAM_BASE = 32'h0000_8000,
  parameter int          FB_WORDS  = 19200,
  parameter int          ADDR_W    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  video_write_buffer_if.slave      bus,
  input  logic                     clr_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic                     oor
);

  localparam int          PTR_W    = $clog2(DEPTH);
  localparam int          LVL_W    = PTR_W + 1;
  localparam logic [31:0] FB_BYTES = 32'(4 * FB_WORDS);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [31:0]       data_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             oor_q, oor_d;
  logic [15:0]      drop_q, drop_d;

  logic [31:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              empty, full, pop, push, drop_full, drop_oor;

  always_comb begin
    offset   = bus.video_addr - VRAM_BASE;
    in_range = (bus.video_addr >= VRAM_BASE) && (offset < FB_BYTES);
    word_idx = offset[ADDR_W+1:2];
  end

  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LVL_W'(DEPTH));
    pop       = !empty && bus.vram_ready;
    // A full FIFO still accepts a store when the head leaves in the same cycle.
    // Because of this, vram_ready reaches push, but it never reaches the head outputs.
    push      = bus.video_we && in_range && (!full || pop);
    drop_full = bus.video_we && in_range && full && !pop;
    drop_oor  = bus.video_we && !in_range;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    oor_d      = oor_q;
    drop_d     = drop_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    if (clr_err) begin
      overflow_d = 1'b0;
      oor_d      = 1'b0;
      drop_d     = '0;
    end else begin
      if (drop_full) overflow_d = 1'b1;
      if (drop_oor)  oor_d      = 1'b1;
      if ((drop_full || drop_oor) && drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      oor_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      oor_q      <= oor_d;
      drop_q     <= drop_d;
    end
  end

  // The storage array has no reset. Occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= word_idx;
      data_mem_q[wr_ptr_q] <= bus.video_data;
    end
  end

  always_comb begin
    bus.vram_valid = !empty;
    bus.vram_addr  = empty ? '0 : addr_mem_q[rd_ptr_q];
    bus.vram_data  = empty ? '0 : data_mem_q[rd_ptr_q];
    level          = level_q;
    overflow       = overflow_q;
    oor            = oor_q;
    drop_count     = drop_q;
  end

endmodule

// File: tb/tb_video_write_buffer.sv
module tb_video_write_buffer;

  localparam int ADDR_W = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_err;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        oor;

  int unsigned tests  = 0;
  int unsigned errors = 0;

  video_write_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  video_write_buffer #(
    .DEPTH     (16),
    .VRAM_BASE (32'h0000_8000),
    .FB_WORDS  (19200),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .clr_err    (clr_err),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .oor        (oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [31:0] e_level;
    logic        e_ovf;
    logic        e_oor;
    logic [31:0] e_drop;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic clr);
    bus.video_we   = we;
    bus.video_addr = a;
    bus.video_data = d;
    bus.vram_ready = rdy;
    clr_err        = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each vector is applied for one edge and then checked.
    vecs[0]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 32'h8010,     32'hAABBCCDD, 1'b1, 1'b0, 1'b1, 32'd4,     32'hAABBCCDD, 32'd1, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b1, 32'h7FFC,     32'h11,       1'b1, 1'b0, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b1, 32'd1};
    vecs[4]  = '{1'b1, 32'h1AC00,    32'h22,       1'b1, 1'b0, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b1, 32'd2};
    vecs[5]  = '{1'b1, 32'h1ABFF,    32'h12345678, 1'b0, 1'b0, 1'b1, 32'd19199, 32'h12345678, 32'd1, 1'b0, 1'b1, 32'd2};
    vecs[6]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'd19199, 32'h12345678, 32'd1, 1'b0, 1'b1, 32'd2};
    vecs[7]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b1, 32'd2};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b0, 32'd0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFC, 32'h33,       1'b0, 1'b0, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b1, 32'd1};
    vecs[10] = '{1'b1, 32'h7FFF,     32'h44,       1'b0, 1'b1, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b0, 32'd0};
    vecs[11] = '{1'b1, 32'h8000,     32'h1,        1'b1, 1'b0, 1'b1, 32'd0,     32'h1,        32'd1, 1'b0, 1'b0, 32'd0};
    vecs[12] = '{1'b1, 32'h8004,     32'h2,        1'b1, 1'b0, 1'b1, 32'd1,     32'h2,        32'd1, 1'b0, 1'b0, 32'd0};
    vecs[13] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'd0,     32'h0,        32'd0, 1'b0, 1'b0, 32'd0};

    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      step();
      chk($sformatf("v%0d valid", i), 32'(bus.vram_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d addr",  i), 32'(bus.vram_addr),  vecs[i].e_addr);
      chk($sformatf("v%0d data",  i), bus.vram_data,       vecs[i].e_data);
      chk($sformatf("v%0d level", i), 32'(level),          vecs[i].e_level);
      chk($sformatf("v%0d ovf",   i), 32'(overflow),       32'(vecs[i].e_ovf));
      chk($sformatf("v%0d oor",   i), 32'(oor),            32'(vecs[i].e_oor));
      chk($sformatf("v%0d drop",  i), 32'(drop_count),     vecs[i].e_drop);
    end

    // Backpressure fill: 16 stores are queued and the 17th is dropped.
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 32'h8000 + 32'(4 * k), 32'(k), 1'b0, 1'b0);
      step();
      if (k == 15) begin
        chk("fill level16", 32'(level), 32'd16);
        chk("fill ovf0", 32'(overflow), 32'd0);
      end
    end
    chk("fill17 level", 32'(level), 32'd16);
    chk("fill17 ovf", 32'(overflow), 32'd1);
    chk("fill17 drop", 32'(drop_count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("drain%0d addr", k), 32'(bus.vram_addr), 32'(k));
      chk($sformatf("drain%0d data", k), bus.vram_data, 32'(k));
      step();
    end
    chk("drain level", 32'(level), 32'd0);
    chk("drain valid", 32'(bus.vram_valid), 32'd0);

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("clr1 ovf", 32'(overflow), 32'd0);

    // Full with simultaneous pop: the new store is accepted and comes out 16th.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 32'h8000 + 32'(4 * k), 32'(100 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h8000 + 32'd200, 32'hBEEF, 1'b1, 1'b0);
    step();
    chk("fullpop level", 32'(level), 32'd16);
    chk("fullpop ovf", 32'(overflow), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 1; k < 16; k++) begin
      #1;
      chk($sformatf("fp%0d data", k), bus.vram_data, 32'(100 + k));
      step();
    end
    chk("fp16 addr", 32'(bus.vram_addr), 32'd50);
    chk("fp16 data", bus.vram_data, 32'hBEEF);
    step();
    chk("fp level0", 32'(level), 32'd0);

    // clr_err with a full FIFO, then reset with 5 entries queued.
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 32'h8000 + 32'(4 * k), 32'(200 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h0000_1000, 32'h0, 1'b0, 1'b0);
    step();
    chk("pre-clr ovf", 32'(overflow), 32'd1);
    chk("pre-clr oor", 32'(oor), 32'd1);
    chk("pre-clr drop", 32'(drop_count), 32'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("clr ovf", 32'(overflow), 32'd0);
    chk("clr oor", 32'(oor), 32'd0);
    chk("clr drop", 32'(drop_count), 32'd0);
    chk("clr level", 32'(level), 32'd16);
    chk("clr head", bus.vram_data, 32'd200);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 11; k++) step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("pre-rst level", 32'(level), 32'd5);
    chk("pre-rst head", bus.vram_data, 32'd211);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst level", 32'(level), 32'd0);
    chk("rst valid", 32'(bus.vram_valid), 32'd0);
    chk("rst addr", 32'(bus.vram_addr), 32'd0);
    chk("rst data", bus.vram_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
